// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared constants for the serial-to-parallel receiver.
package s2p_pkg;
  localparam int S2P_WIDTH = 4;

  // Bit-counter width for a given word length (never narrower than 1 bit)
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(S2P_WIDTH);
endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial link input plus parallel word handshake of the receiver.
interface serial_to_parallel_rx_if
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH
);
  logic             serial_in;
  logic             shift_en;
  logic             sync;
  logic             data_ack;
  logic             clear_err;
  logic [WIDTH-1:0] parallel_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;

  // Link/consumer side: drives bits and acks, observes the word slot
  modport master (
    output serial_in, shift_en, sync, data_ack, clear_err,
    input  parallel_out, data_valid, busy, overrun
  );

  // Receiver side
  modport slave (
    input  serial_in, shift_en, sync, data_ack, clear_err,
    output parallel_out, data_valid, busy, overrun
  );
endinterface

// File: rtl/serial_to_parallel_rx_out_slot.sv
// Single-entry output slot: holds the last delivered word, its valid flag
// and the sticky overrun flag for words that arrived while the slot was full.
module s2p_out_slot
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             complete,
  input  logic             data_ack,
  input  logic             clear_err,
  output logic [WIDTH-1:0] parallel_out,
  output logic             data_valid,
  output logic             overrun
);
  logic slot_free;
  logic drop;

  // An ack in the same cycle frees the slot for an arriving word
  assign slot_free = !data_valid || data_ack;
  assign drop      = complete && !slot_free;

  // Deliver, ack, and record drops; a drop beats clear_err in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= '0;
      data_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (complete && slot_free) begin
        parallel_out <= word;
        data_valid   <= 1'b1;
      end else if (data_ack) begin
        data_valid   <= 1'b0;
      end
      if (drop)           overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
    end
  end
endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: shifts MSB-first bits into a word, with
// gapped sampling and word-boundary resync, then hands words to the slot.
module serial_to_parallel_rx
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_to_parallel_rx_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             complete;

  // A sample during sync starts a fresh word, so it can never complete one
  assign word     = {sr[WIDTH-2:0], bus.serial_in};
  assign complete = bus.shift_en && !bus.sync && (cnt == LAST);
  assign bus.busy = (cnt != '0);

  // Shift register and bit counter; sync restarts the word boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.sync) begin
      if (bus.shift_en) begin
        sr  <= {{(WIDTH-1){1'b0}}, bus.serial_in};
        cnt <= CW'(1);
      end else begin
        sr  <= '0;
        cnt <= '0;
      end
    end else if (bus.shift_en) begin
      sr  <= word;
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  s2p_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk          (clk),
    .rst          (rst),
    .word         (word),
    .complete     (complete),
    .data_ack     (bus.data_ack),
    .clear_err    (bus.clear_err),
    .parallel_out (bus.parallel_out),
    .data_valid   (bus.data_valid),
    .overrun      (bus.overrun)
  );
endmodule
